// File: rtl/hs_pkg.sv
// Shared types and width helpers for the round-robin handshake arbiter.
package hs_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   localparam int NUM_REQ_DEF   = 4;
   localparam int DATA_W_DEF    = 8;
   localparam int MAX_BURST_DEF = 4;

   // Index width never collapses to zero bits, even for a single requester.
   function automatic int gid_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int cnt_w(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   idx,
   output logic               hit
);

   logic [2*NUM_REQ-1:0] dbl;

   // Low copy masked below ptr, high copy unmasked: the lowest set bit of the
   // doubled vector is the round-robin winner, folded back modulo NUM_REQ.
   always_comb begin
      dbl = {req, req};
      for (int j = 0; j < NUM_REQ; j++) begin
         if (j < int'(ptr)) dbl[j] = 1'b0;
      end
      idx = '0;
      hit = 1'b0;
      for (int j = 2*NUM_REQ-1; j >= 0; j--) begin
         if (dbl[j]) begin
            hit = 1'b1;
            idx = IDX_W'(j % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready slave channel among NUM_REQ masters,
// with per-grant burst locking up to MAX_BURST beats and no data storage.
module hs_rr_arbiter
   import hs_pkg::*;
#(
   parameter int NUM_REQ   = NUM_REQ_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF,
   parameter int GID_W     = gid_w(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        m_valid,
   input  logic [NUM_REQ*DATA_W-1:0] m_data,
   output logic [NUM_REQ-1:0]        m_ready,
   output logic                      s_valid,
   output logic [DATA_W-1:0]         s_data,
   input  logic                      s_ready,
   output logic [GID_W-1:0]          grant_id,
   output logic                      busy
);

   localparam int CNT_W = cnt_w(MAX_BURST);

   state_e                          state_q, state_d;
   logic [GID_W-1:0]                ptr_q, ptr_d;
   logic [GID_W-1:0]                gid_q, gid_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [GID_W-1:0]                pick_idx;
   logic                            pick_hit;
   logic                            xfer;
   logic                            rel;
   logic [NUM_REQ-1:0][DATA_W-1:0]  m_data_a;

   assign m_data_a = m_data;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (GID_W)
   ) u_pick (
      .req (m_valid),
      .ptr (ptr_q),
      .idx (pick_idx),
      .hit (pick_hit)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gid_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      cnt_d   = cnt_q;
      m_ready = '0;
      s_valid = 1'b0;
      s_data  = '0;
      xfer    = 1'b0;
      rel     = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_hit) begin
               gid_d   = pick_idx;
               cnt_d   = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            // Owner's channel passes straight through; ready is not gated by valid.
            s_valid        = m_valid[gid_q];
            s_data         = m_data_a[gid_q];
            m_ready[gid_q] = s_ready;
            xfer           = m_valid[gid_q] && s_ready;
            if (xfer) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(MAX_BURST-1)) rel = 1'b1;
            end else if (!m_valid[gid_q]) begin
               rel = 1'b1;
            end
            if (rel) begin
               state_d = IDLE;
               ptr_d   = (gid_q == GID_W'(NUM_REQ-1)) ? '0 : gid_q + GID_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign grant_id = gid_q;
   assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Directed self-checking bench for hs_rr_arbiter (4 masters, 8-bit data, bursts of 4).
module tb_hs_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    m_valid;
   logic [N*DW-1:0] m_data;
   logic [N-1:0]    m_ready;
   logic            s_valid;
   logic [DW-1:0]   s_data;
   logic            s_ready;
   logic [1:0]      grant_id;
   logic            busy;

   // Each master sends {id, seq}; seq advances only when its beat is accepted.
   logic [3:0]      seq [N];
   int              checks = 0;
   int              errors = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < N; i++) m_data[i*DW +: DW] = {4'(i), seq[i]};
   end

   hs_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk      (clk),
      .rst      (rst),
      .m_valid  (m_valid),
      .m_data   (m_data),
      .m_ready  (m_ready),
      .s_valid  (s_valid),
      .s_data   (s_data),
      .s_ready  (s_ready),
      .grant_id (grant_id),
      .busy     (busy)
   );

   task automatic tick();
      logic [N-1:0] acc;
      acc = m_valid & m_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (acc[i]) seq[i] = seq[i] + 4'd1;
      #1;
   endtask

   task automatic clr_seq();
      for (int i = 0; i < N; i++) seq[i] = 4'd0;
   endtask

   task automatic rst_pulse();
      #2 rst = 1'b0;
      #3 rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; m_valid = '0; s_ready = 1'b0; clr_seq();
      #1 rst = 1'b0;
      #1;
      checks++;
      if ({m_ready, s_valid, grant_id, busy, s_data} !== '0) begin
         errors++; $display("FAIL reset_init: got %h exp 0", {m_ready, s_valid, grant_id, busy, s_data});
      end
      #1 rst = 1'b1;
      m_valid = 4'b0100; s_ready = 1'b1;
      tick();
      m_valid = 4'b1111;
      tick();
      checks++;
      if ({busy, grant_id} !== {1'b1, 2'd2}) begin
         errors++; $display("FAIL reset_pre: got %b exp %b", {busy, grant_id}, 3'b110);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({m_ready, s_valid, grant_id, busy, s_data} !== '0) begin
         errors++; $display("FAIL reset_async: got %h exp 0", {m_ready, s_valid, grant_id, busy, s_data});
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({s_valid, busy} !== 2'b00) begin
         errors++; $display("FAIL reset_release: got %b exp 00", {s_valid, busy});
      end
      tick();
      checks++;
      if ({busy, s_valid, grant_id, s_data} !== {1'b1, 1'b1, 2'd0, 8'h00}) begin
         errors++; $display("FAIL reset_regrant: got %h exp %h", {busy, s_valid, grant_id, s_data}, {1'b1, 1'b1, 2'd0, 8'h00});
      end
   endtask

   task automatic test_rotation();
      logic [7:0] exp_d;
      rst_pulse(); clr_seq();
      m_valid = 4'b1111; s_ready = 1'b1;
      #1;
      checks++;
      if (s_valid !== 1'b0) begin
         errors++; $display("FAIL rot_idle: got %b exp 0", s_valid);
      end
      for (int r = 0; r < 5; r++) begin
         for (int b = 0; b < MB; b++) begin
            tick();
            exp_d = {4'(r % 4), 4'((r / 4) * 4 + b)};
            checks++;
            if ({busy, s_valid, grant_id, m_ready, s_data} !== {1'b1, 1'b1, 2'(r % 4), 4'(1 << (r % 4)), exp_d}) begin
               errors++;
               $display("FAIL rot_beat r%0d b%0d: got %h exp %h", r, b, {busy, s_valid, grant_id, m_ready, s_data},
                        {1'b1, 1'b1, 2'(r % 4), 4'(1 << (r % 4)), exp_d});
            end
         end
         tick();
         checks++;
         if ({busy, s_valid, m_ready} !== 6'b0) begin
            errors++; $display("FAIL rot_bubble r%0d: got %b exp 0", r, {busy, s_valid, m_ready});
         end
      end
   endtask

   task automatic test_early_release_and_wrap();
      rst_pulse(); clr_seq();
      m_valid = 4'b0100; s_ready = 1'b1;
      #1;
      for (int b = 0; b < 2; b++) begin
         tick();
         checks++;
         if ({grant_id, s_valid, s_data} !== {2'd2, 1'b1, 4'd2, 4'(b)}) begin
            errors++; $display("FAIL early_beat b%0d: got %h exp %h", b, {grant_id, s_valid, s_data}, {2'd2, 1'b1, 4'd2, 4'(b)});
         end
      end
      tick();
      m_valid = 4'b1001;
      #1;
      checks++;
      if ({busy, s_valid, m_ready} !== {1'b1, 1'b0, 4'b0100}) begin
         errors++; $display("FAIL early_drop: got %b exp %b", {busy, s_valid, m_ready}, 6'b100100);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL early_bubble: got %b exp 0", busy);
      end
      for (int b = 0; b < MB; b++) begin
         tick();
         checks++;
         if ({grant_id, s_valid, s_data} !== {2'd3, 1'b1, 4'd3, 4'(b)}) begin
            errors++; $display("FAIL early_m3 b%0d: got %h exp %h", b, {grant_id, s_valid, s_data}, {2'd3, 1'b1, 4'd3, 4'(b)});
         end
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL wrap_bubble: got %b exp 0", busy);
      end
      tick();
      checks++;
      if ({grant_id, s_valid, s_data} !== {2'd0, 1'b1, 8'h00}) begin
         errors++; $display("FAIL wrap_m0: got %h exp %h", {grant_id, s_valid, s_data}, {2'd0, 1'b1, 8'h00});
      end
   endtask

   task automatic test_backpressure();
      int got;
      rst_pulse(); clr_seq();
      m_valid = 4'b1111; got = 0;
      for (int c = 0; c < 80 && got < 16; c++) begin
         s_ready = (c % 4 != 3);
         #1;
         if (s_valid && s_ready) begin
            checks++;
            if ({grant_id, s_data} !== {2'(got / 4), 4'(got / 4), 4'(got % 4)}) begin
               errors++;
               $display("FAIL bp_beat %0d: got %h exp %h", got, {grant_id, s_data}, {2'(got / 4), 4'(got / 4), 4'(got % 4)});
            end
            got++;
         end
         tick();
      end
      checks++;
      if (got != 16) begin
         errors++; $display("FAIL bp_count: got %0d exp 16", got);
      end
   endtask

   task automatic test_latency_single();
      rst_pulse(); clr_seq();
      m_valid = '0; s_ready = 1'b1;
      tick(); tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL lat_idle: got %b exp 0", busy);
      end
      m_valid = 4'b0010;
      #1;
      checks++;
      if (s_valid !== 1'b0) begin
         errors++; $display("FAIL lat_t0: got %b exp 0", s_valid);
      end
      for (int b = 0; b < MB; b++) begin
         tick();
         checks++;
         if ({grant_id, s_valid, s_data} !== {2'd1, 1'b1, 4'd1, 4'(b)}) begin
            errors++; $display("FAIL lat_beat b%0d: got %h exp %h", b, {grant_id, s_valid, s_data}, {2'd1, 1'b1, 4'd1, 4'(b)});
         end
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL single_bubble: got %b exp 0", busy);
      end
      tick();
      checks++;
      if ({grant_id, s_valid, s_data} !== {2'd1, 1'b1, 8'h14}) begin
         errors++; $display("FAIL single_regrant: got %h exp %h", {grant_id, s_valid, s_data}, {2'd1, 1'b1, 8'h14});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_rotation();
      test_early_release_and_wrap();
      test_backpressure();
      test_latency_single();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
